// File: rtl/sram_ring_pkg.sv
// Shared types for the sram_ring bank ring.
// Host op codes and request FSM states.
package sram_ring_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_ROTATE = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ROT_WR = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/sram_ring_bank.sv
// Behavioural single-port SRAM bank, 1-cycle read latency.
// Per-bit write mask; read data held until the next read.
module sram_ring_bank #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              ce_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [WIDTH-1:0]  wd_in,
  input  logic [WIDTH-1:0]  w_mask_in,
  output logic [WIDTH-1:0]  rd_out
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) begin
        mem[addr_in] <= (mem[addr_in] & ~w_mask_in)
                      | (wd_in & w_mask_in);
      end else begin
        rd_out <= mem[addr_in];
      end
    end
  end

endmodule

// File: rtl/sram_ring.sv
// Ring of single-port SRAM banks behind a serialising request FSM.
// ROTATE moves one word address one bank forward in every bank.
module sram_ring
  import sram_ring_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int WIDTH     = 7,
  parameter int DEPTH     = 64,
  parameter int ROT_CNT_W = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BANK_W =
    (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [BANK_W-1:0]    req_bank,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [WIDTH-1:0]     req_mask,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [ROT_CNT_W-1:0] rot_count
);

  localparam logic [BANK_W:0] NB_X =
    NUM_BANKS[BANK_W:0];
  localparam logic [ADDR_W:0] DP_X =
    DEPTH[ADDR_W:0];

  state_e              state;
  logic [1:0]          op_q;
  logic [BANK_W-1:0]   bank_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [WIDTH-1:0]    mask_q;
  logic                err_q;
  logic                req_err;

  logic [NUM_BANKS-1:0] ce;
  logic                 we;
  logic [WIDTH-1:0]     mask;
  logic [WIDTH-1:0]     wd [NUM_BANKS];
  logic [WIDTH-1:0]     rd [NUM_BANKS];

  always_comb begin
    req_err = 1'b0;
    unique case (1'b1)
      (req_op == 2'd3):
        req_err = 1'b1;
      ({1'b0, req_addr} >= DP_X):
        req_err = 1'b1;
      (req_op != OP_ROTATE &&
       {1'b0, req_bank} >= NB_X):
        req_err = 1'b1;
      default:
        req_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rot_count <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            bank_q  <= req_bank;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            mask_q  <= req_mask;
            err_q   <= req_err;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (err_q) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else if (op_q == OP_ROTATE) begin
            state <= ROT_WR;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        ROT_WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rot_count <= rot_count + ROT_CNT_W'(1);
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign we = (state == ROT_WR) ||
              (state == ISSUE && op_q == OP_WRITE);
  assign mask = (state == ROT_WR) ? '1 : mask_q;

  assign rsp_data =
    (rsp_valid && !rsp_err && op_q == OP_READ)
      ? rd[bank_q] : '0;

  // ce is gated by rst_n so a reset edge never lands an access
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam int P = (b + NUM_BANKS - 1) % NUM_BANKS;

    assign ce[b] = rst_n && (
      (state == ROT_WR) ||
      (state == ISSUE && !err_q &&
       (op_q == OP_ROTATE || bank_q == BANK_W'(b))));

    assign wd[b] = (state == ROT_WR) ? rd[P] : wdata_q;

    sram_ring_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk       (clk),
      .ce_in     (ce[b]),
      .we_in     (we),
      .addr_in   (addr_q),
      .wd_in     (wd[b]),
      .w_mask_in (mask),
      .rd_out    (rd[b])
    );
  end

endmodule

// File: tb/tb_sram_ring.sv
// Directed bench for sram_ring: 3 banks, 7-bit words, 4-bit rot_count.
// Expected values are hand-derived ring contents and latencies.
module tb_sram_ring;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [1:0] req_bank;
  logic [5:0] req_addr;
  logic [6:0] req_wdata;
  logic [6:0] req_mask;
  logic       rsp_valid;
  logic [6:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic [3:0] rot_count;

  int errs;
  int checks;
  int ce_cnt;
  int rsp_cnt;
  int acc_cnt;

  sram_ring #(
    .NUM_BANKS (3),
    .WIDTH     (7),
    .DEPTH     (64),
    .ROT_CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_bank  (req_bank),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .rot_count (rot_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (|dut.ce) ce_cnt++;
    if (rsp_valid) rsp_cnt++;
    if (req_valid && req_ready) acc_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [1:0] op,
                       input logic [1:0] bank,
                       input logic [5:0] addr,
                       input logic [6:0] wdat,
                       input logic [6:0] mk,
                       output logic [6:0] rdata,
                       output logic err,
                       output int lat);
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_bank  = bank;
    req_addr  = addr;
    req_wdata = wdat;
    req_mask  = mk;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (rsp_valid) begin
        lat   = k;
        rdata = rsp_data;
        err   = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [1:0] bank,
                        input logic [5:0] addr,
                        input logic [6:0] exp);
    logic [6:0] d;
    logic       e;
    int         l;
    do_op(2'd0, bank, addr, 7'h0, 7'h0, d, e, l);
    chk(tag, {e, d}, {1'b0, exp});
  endtask

  initial begin
    logic [6:0] d;
    logic       e;
    int         l;
    int         c0;
    int         r0;
    int         a0;

    errs = 0; checks = 0;
    ce_cnt = 0; rsp_cnt = 0; acc_cnt = 0;
    rst_n = 1'b0; req_valid = 1'b0;
    req_op = 2'd0; req_bank = 2'd0; req_addr = 6'd0;
    req_wdata = 7'h0; req_mask = 7'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rot_count", rot_count, 0);

    // ring rotate of address 5
    do_op(2'd1, 2'd0, 6'd5, 7'h11, 7'h7F, d, e, l);
    chk("wr_lat", l, 2);
    chk("wr_err", e, 0);
    do_op(2'd1, 2'd1, 6'd5, 7'h22, 7'h7F, d, e, l);
    do_op(2'd1, 2'd2, 6'd5, 7'h33, 7'h7F, d, e, l);
    do_op(2'd2, 2'd0, 6'd5, 7'h00, 7'h00, d, e, l);
    chk("rot_lat", l, 3);
    chk("rot_data", d, 0);
    chk("rot_count1", rot_count, 1);
    rd_chk("rot_b0", 2'd0, 6'd5, 7'h33);
    do_op(2'd0, 2'd1, 6'd5, 7'h0, 7'h0, d, e, l);
    chk("rd_lat", l, 2);
    chk("rot_b1", d, 7'h11);
    rd_chk("rot_b2", 2'd2, 6'd5, 7'h22);

    // masked write at the top address
    do_op(2'd1, 2'd1, 6'd63, 7'h7F, 7'h7F, d, e, l);
    do_op(2'd1, 2'd1, 6'd63, 7'h00, 7'h0F, d, e, l);
    do_op(2'd0, 2'd1, 6'd63, 7'h0, 7'h0, d, e, l);
    chk("mask_data", d, 7'h70);
    chk("mask_lat", l, 2);

    // error requests
    wait_ready();
    c0 = ce_cnt;
    do_op(2'd0, 2'd3, 6'd5, 7'h0, 7'h0, d, e, l);
    chk("err_rd_err", e, 1);
    chk("err_rd_data", d, 0);
    chk("err_rd_lat", l, 2);
    do_op(2'd1, 2'd3, 6'd5, 7'h55, 7'h7F, d, e, l);
    chk("err_wr_err", e, 1);
    do_op(2'd3, 2'd0, 6'd5, 7'h55, 7'h7F, d, e, l);
    chk("err_op3_err", e, 1);
    @(posedge clk); #1;
    chk("err_no_ce", ce_cnt - c0, 0);
    chk("err_rot_count", rot_count, 1);
    rd_chk("err_b0", 2'd0, 6'd5, 7'h33);
    rd_chk("err_b1", 2'd1, 6'd5, 7'h11);
    rd_chk("err_b2", 2'd2, 6'd5, 7'h22);

    // reset in ISSUE of a ROTATE
    wait_ready();
    req_valid = 1'b1;
    req_op = 2'd2; req_bank = 2'd0; req_addr = 6'd5;
    @(posedge clk); #1;
    chk("abort_busy", busy, 1);
    c0 = ce_cnt;
    r0 = rsp_cnt;
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_ready", req_ready, 1);
    chk("abort_no_ce", ce_cnt - c0, 0);
    chk("abort_no_rsp", rsp_cnt - r0, 0);
    chk("abort_rot_count", rot_count, 0);
    rd_chk("abort_b0", 2'd0, 6'd5, 7'h33);
    rd_chk("abort_b1", 2'd1, 6'd5, 7'h11);
    rd_chk("abort_b2", 2'd2, 6'd5, 7'h22);

    // counter wrap; 15 rotations restore a 3-bank ring
    do_op(2'd1, 2'd0, 6'd0, 7'h01, 7'h7F, d, e, l);
    do_op(2'd1, 2'd1, 6'd0, 7'h02, 7'h7F, d, e, l);
    do_op(2'd1, 2'd2, 6'd0, 7'h04, 7'h7F, d, e, l);
    for (int i = 0; i < 15; i++)
      do_op(2'd2, 2'd0, 6'd0, 7'h0, 7'h0, d, e, l);
    chk("wrap_cnt15", rot_count, 15);
    rd_chk("wrap15_b0", 2'd0, 6'd0, 7'h01);
    rd_chk("wrap15_b1", 2'd1, 6'd0, 7'h02);
    rd_chk("wrap15_b2", 2'd2, 6'd0, 7'h04);
    do_op(2'd2, 2'd0, 6'd0, 7'h0, 7'h0, d, e, l);
    chk("wrap_cnt16", rot_count, 0);
    rd_chk("wrap16_b0", 2'd0, 6'd0, 7'h04);
    rd_chk("wrap16_b1", 2'd1, 6'd0, 7'h01);
    rd_chk("wrap16_b2", 2'd2, 6'd0, 7'h02);
    rd_chk("wrap16_a5", 2'd0, 6'd5, 7'h33);

    // request held through busy cycles
    wait_ready();
    a0 = acc_cnt;
    r0 = rsp_cnt;
    req_valid = 1'b1;
    req_op = 2'd0; req_bank = 2'd0; req_addr = 6'd0;
    @(posedge clk); #1;
    chk("hold_not_ready", req_ready, 0);
    repeat (11) @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_accepts", acc_cnt - a0, 4);
    chk("hold_rsps", rsp_cnt - r0, 4);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
